// File: rtl/mux_8to1_rr_pkg.sv
// Shared constants and helpers for the 8-way round-robin stream merge.
package mux_pkg;
   localparam int N_CH  = 8;
   localparam int SEL_W = 3;

   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_CH; i++)
         if (oh[i]) idx = idx | SEL_W'(i);
      return idx;
   endfunction
endpackage

// File: rtl/mux_8to1_rr_if.sv
// Stream bundle: eight valid/ready input channels and one tagged output stream.
interface mux_8to1_rr_if #(
   parameter int WIDTH = 8
) ();
   logic [mux_pkg::N_CH-1:0]             in_valid;
   logic [mux_pkg::N_CH-1:0][WIDTH-1:0]  in_data;
   logic [mux_pkg::N_CH-1:0]             in_ready;
   logic                                 out_valid;
   logic [WIDTH-1:0]                     out_data;
   logic [mux_pkg::SEL_W-1:0]            out_sel;
   logic                                 out_ready;

   // master = producer/consumer environment, slave = the multiplexer
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/mux_8to1_rr_arb.sv
// Round-robin 8-way arbiter; owns the priority pointer, which moves only on an actual grant.
module rr_arbiter_8
   import mux_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  req,
   input  logic             advance,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] gnt_idx
);
   logic [SEL_W-1:0] last_q, last_d;
   logic [SEL_W-1:0] scan_idx;

   // Scan starting one past the last winner; the 3-bit add wraps 7->0 for free.
   always_comb begin
      gnt      = '0;
      scan_idx = '0;
      for (int k = 1; k <= N_CH; k++) begin
         scan_idx = last_q + SEL_W'(k);
         if (req[scan_idx] && (gnt == '0)) gnt[scan_idx] = 1'b1;
      end
   end

   always_comb begin
      gnt_idx = onehot_to_idx(gnt);
      last_d  = last_q;
      if (advance && (gnt != '0)) last_d = gnt_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) last_q <= SEL_W'(N_CH - 1);
      else     last_q <= last_d;
   end
endmodule

// File: rtl/mux_8to1_rr.sv
// Round-robin 8-to-1 stream merge with a registered, source-tagged output word.
module mux_8to1_rr
   import mux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   mux_8to1_rr_if.slave  bus
);
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;
   logic             load, win, adv;
   logic [N_CH-1:0]  gnt;
   logic [SEL_W-1:0] gnt_idx;

   rr_arbiter_8 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.in_valid),
      .advance (adv),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Output stage takes a new word when empty or being drained this cycle.
   always_comb begin
      load        = ~out_valid_q | bus.out_ready;
      win         = |gnt;
      adv         = load & win & ~rst;
      bus.in_ready = (load && !rst) ? gnt : '0;

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (load) begin
         if (win) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[gnt_idx];
            out_sel_d   = gnt_idx;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_8to1_rr.sv
// Directed bench for mux_8to1_rr with a behavioural arbiter model and an output scoreboard.
module tb_mux_8to1_rr;
   typedef struct {
      logic [2:0] sel;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mux_8to1_rr_if #(.WIDTH(8)) bus ();

   mux_8to1_rr #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int find_win(input logic [7:0] v, input logic [2:0] last);
      for (int k = 1; k <= 8; k++) begin
         int c;
         c = (int'(last) + k) % 8;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // Reference model state
   logic       m_init = 1'b0;
   logic       m_vld  = 1'b0;
   logic [2:0] m_last = 3'd7;
   exp_t       sb[$];

   always @(posedge clk) begin
      int   g;
      exp_t e;
      if (rst) begin
         m_init = 1'b1;
         m_vld  = 1'b0;
         m_last = 3'd7;
         sb.delete();
      end else if (m_init) begin
         g = find_win(bus.in_valid, m_last);
         if (!m_vld || bus.out_ready) begin
            if (g >= 0) begin
               m_vld  = 1'b1;
               m_last = 3'(g);
               e.sel  = 3'(g);
               e.data = bus.in_data[g];
               sb.push_back(e);
            end else begin
               m_vld = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] exp_rdy;
      int         g;
      exp_t       e;
      if (m_init) begin
         g = find_win(bus.in_valid, m_last);
         exp_rdy = '0;
         if (!rst && (!m_vld || bus.out_ready) && g >= 0) exp_rdy[g] = 1'b1;
         chk("mon_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         chk("mon_out_valid", 32'(bus.out_valid), 32'(m_vld));
         if (!rst && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sb_sel", 32'(bus.out_sel), 32'(e.sel));
               chk("sb_data", 32'(bus.out_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      int seq[3];
      seq = '{0, 3, 0};
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) bus.in_data[i] = 8'(8'h10 + i);

      // 1) reset with every channel requesting
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_out_data",  32'(bus.out_data),  32'd0);
         chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
         chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
         @(posedge clk); #1;
      end

      // 2) single channel
      rst = 1'b0;
      bus.in_valid   = 8'h20;
      bus.in_data[5] = 8'hA5;
      @(negedge clk);
      chk("single_in_ready", 32'(bus.in_ready), 32'h20);
      @(posedge clk); #1;
      bus.in_valid   = 8'h00;
      bus.in_data[5] = 8'h15;
      @(negedge clk);
      chk("single_valid", 32'(bus.out_valid), 32'd1);
      chk("single_sel",   32'(bus.out_sel),   32'd5);
      chk("single_data",  32'(bus.out_data),  32'hA5);

      // 3) all channels valid, full rotation from a fresh pointer
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); @(negedge clk);
         chk("rr_valid", 32'(bus.out_valid), 32'd1);
         chk("rr_sel",   32'(bus.out_sel),   32'(k % 8));
         chk("rr_data",  32'(bus.out_data),  32'(8'h10 + (k % 8)));
      end

      // 4) backpressure: word from channel 1 held for 5 cycles
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_sel",      32'(bus.out_sel),   32'd1);
         chk("bp_data",     32'(bus.out_data),  32'h11);
         chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
         @(posedge clk);
      end
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_rdy", 32'(bus.in_ready), 32'h04);
      @(posedge clk); @(negedge clk);
      chk("bp_next_sel", 32'(bus.out_sel), 32'd2);

      // 5) wrap and skip from last=6 with channels 0 and 3 requesting
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 8'h40;
      @(posedge clk); #1;
      bus.in_valid = 8'h09;
      @(negedge clk);
      chk("wrap_seed_sel", 32'(bus.out_sel), 32'd6);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         chk("wrap_sel",  32'(bus.out_sel),  32'(seq[k]));
         chk("wrap_data", 32'(bus.out_data), 32'(8'h10 + seq[k]));
      end

      // 6) reset while a word is held; that word must vanish
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_sel",   32'(bus.out_sel),   32'd3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 8'h0C;
      @(negedge clk);
      chk("midrst_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_rdy",   32'(bus.in_ready),  32'h04);
      @(posedge clk); @(negedge clk);
      chk("midrst_sel",  32'(bus.out_sel),  32'd2);
      chk("midrst_data", 32'(bus.out_data), 32'h12);

      // drain and confirm nothing is left outstanding
      @(posedge clk); #1;
      bus.in_valid = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
